// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link: FSM encoding, line levels
// and the bit period both ends of the link default to.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_sync.sv
// Two-flop line synchroniser with a falling-edge strobe on the synchronised line.
module serial_sync
  import serial_pkg::*;
(
  input  logic sclk,
  input  logic rst,
  input  logic idata,
  output logic s_line,
  output logic fall
);

  logic       s_meta;
  logic       s_line_q;
  logic [2:0] primed;

  always_ff @(posedge sclk) begin
    if (rst) begin
      s_meta   <= IDLE_LVL;
      s_line   <= IDLE_LVL;
      s_line_q <= IDLE_LVL;
      primed   <= '0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous value
      // of its neighbour, which is what turns these three lines into a pipeline.
      s_meta   <= idata;
      s_line   <= s_meta;
      s_line_q <= s_line;
      primed   <= {primed[1:0], 1'b1};
    end
  end

  // The idle-high reset values would fake a 1->0 edge if the line was already
  // low at release, so edges count only once every stage holds a real sample.
  assign fall = primed[2] & s_line_q & ~s_line;

endmodule

// File: rtl/serial_rx.sv
// Serial receiver: start detection, mid-bit sampling, LSB-first deserialisation,
// stop-bit check and a one-entry valid/ready output buffer.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              idata,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MID   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic s_line;
  logic fall;

  serial_sync u_sync (
    .sclk   (sclk),
    .rst    (rst),
    .idata  (idata),
    .s_line (s_line),
    .fall   (fall)
  );

  state_t            state,      state_next;
  logic [CNT_W-1:0]  cnt,        cnt_next;
  logic [IDX_W-1:0]  idx,        idx_next;
  logic [DATA_W-1:0] shreg,      shreg_next;
  logic              deliver;
  logic              stop_bad;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    deliver    = 1'b0;
    stop_bad   = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      // Re-check the start bit half a period in to reject line glitches.
      START: begin
        if (cnt == CNT_MID) begin
          cnt_next = '0;
          if (s_line == START_BIT) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {s_line, shreg[DATA_W-1:1]};
          if (idx == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (s_line == STOP_BIT) begin
            deliver = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A word arriving while the buffer is full and not being drained is dropped;
  // if the consumer takes the old word in the same cycle, the new one replaces it.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= deliver & rx_valid & ~rx_ready;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
